// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam int unsigned SA_W_DEFAULT = 8;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the datapath slice of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  logic ab_x;

  assign ab_x  = a ^ b;
  assign sum   = ab_x ^ c;
  assign carry = (a & b) | (c & ab_x);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: one full_adder slice, LSB first, with a registered carry.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned W = SA_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic         ovf,
`endif
  output logic         busy
);

  localparam int unsigned CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(W - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_sr_q, a_sr_d;
  logic [W-1:0]     b_sr_q, b_sr_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;
  logic             fa_sum, fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  full_adder u_fa (
    .a     (a_sr_q[0]),
    .b     (b_sr_q[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d       = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d  = op_a;
          b_sr_d  = op_b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        // New sum bit enters at the MSB so the LSB lands at bit 0 after W shifts.
        sum_d   = (sum_q >> 1) | (W'(fa_sum) << (W - 1));
        carry_d = fa_carry;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LastCnt) begin
          cout_d      = fa_carry;
          out_valid_d = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d       = carry_q ^ fa_carry;
`endif
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: a W=8 instance and a W=3 instance for the exhaustive sweep.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, busy8;
  logic [7:0] op_a8, op_b8, sum8;
  logic       in_valid3, in_ready3, cin3, out_valid3, out_ready3, cout3, busy3;
  logic [2:0] op_a3, op_b3, sum3;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf3;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  serial_adder #(.W(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .op_a      (op_a8),
    .op_b      (op_b8),
    .cin       (cin8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf       (ovf8),
`endif
    .busy      (busy8)
  );

  serial_adder #(.W(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .op_a      (op_a3),
    .op_b      (op_b3),
    .cin       (cin3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .sum       (sum3),
    .cout      (cout3),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf       (ovf3),
`endif
    .busy      (busy3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one W=8 operation, then check latency and result; leaves the DUT in DONE.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic [8:0] exp);
    int lat;
    op_a8 = a; op_b8 = b; cin8 = c; in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0;
    chk({tag, "_inready_low"}, in_ready8, 1'b0);
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, 8);
    chk({tag, "_result"}, {cout8, sum8}, exp);
  endtask

  task automatic release8(input string tag);
    out_ready8 = 1'b1;
    step();
    out_ready8 = 1'b0;
    chk({tag, "_rel_outvalid"}, out_valid8, 1'b0);
    chk({tag, "_rel_inready"}, in_ready8, 1'b1);
  endtask

  initial begin
    int ov_seen, prev_acc, acc, k;
    logic [2:0] a3, b3;
    logic       c3;
    rst_n = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; op_a8 = '0; op_b8 = '0; cin8 = 1'b0;
    in_valid3 = 1'b0; out_ready3 = 1'b0; op_a3 = '0; op_b3 = '0; cin3 = 1'b0;
    #3;
    chk("reset_inready", in_ready8, 1'b1);
    chk("reset_outvalid", out_valid8, 1'b0);
    chk("reset_busy", busy8, 1'b0);
    chk("reset_sum_cout", {cout8, sum8}, 9'h000);
    #9 rst_n = 1'b1;
    step();

    // Basic add
    run8("basic", 8'h3C, 8'h0A, 1'b0, 9'h046);
    release8("basic");

    // Full carry chain
    run8("chain", 8'hFF, 8'h00, 1'b1, 9'h100);
`ifdef SERIAL_ADDER_OVF_EN
    chk("chain_ovf", ovf8, 1'b0);
`endif
    release8("chain");

    // Reset mid-SHIFT after 3 shifts; cout is still 1 from the previous result
    op_a8 = 8'hFF; op_b8 = 8'h01; cin8 = 1'b0; in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0;
    step(); step(); step();
    chk("midrst_busy_before", busy8, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_inready", in_ready8, 1'b1);
    chk("midrst_busy", busy8, 1'b0);
    chk("midrst_outvalid", out_valid8, 1'b0);
    chk("midrst_sum_cout", {cout8, sum8}, 9'h000);
    #2 rst_n = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid8) ov_seen++;
    end
    chk("midrst_no_outvalid", ov_seen, 0);
    chk("midrst_idle", in_ready8, 1'b1);

    // Signed overflow cases
    run8("ovf_pos", 8'h7F, 8'h01, 1'b0, 9'h080);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf_pos_flag", ovf8, 1'b1);
`endif
    release8("ovf_pos");
    run8("ovf_neg", 8'h80, 8'h80, 1'b0, 9'h100);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf_neg_flag", ovf8, 1'b1);
`endif
    release8("ovf_neg");

    // Backpressure: hold DONE with new requests pending
    run8("bp", 8'hA5, 8'h3C, 1'b1, 9'h0E2);
    for (int i = 0; i < 5; i++) begin
      in_valid8 = 1'b1;
      op_a8 = 8'(i * 37 + 1); op_b8 = 8'(i * 11 + 5); cin8 = i[0];
      step();
      chk("bp_outvalid", out_valid8, 1'b1);
      chk("bp_result", {cout8, sum8}, 9'h0E2);
      chk("bp_inready", in_ready8, 1'b0);
    end
    in_valid8 = 1'b0;
    release8("bp");

    // Exhaustive W=3, back-to-back with in_valid and out_ready held high
    in_valid3 = 1'b1;
    out_ready3 = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 128; i++) begin
      a3 = i[6:4];
      b3 = i[3:1];
      c3 = i[0];
      op_a3 = a3; op_b3 = b3; cin3 = c3;
      k = 0;
      while (!in_ready3 && k < 10) begin
        step();
        k++;
      end
      step();
      acc = cyc;
      if (i > 0) chk("w3_interval", acc - prev_acc, 5);
      prev_acc = acc;
      op_a3 = ~a3; op_b3 = ~b3; cin3 = ~c3;
      k = 0;
      while (!out_valid3 && k < 10) begin
        step();
        k++;
      end
      chk("w3_result", {cout3, sum3}, 4'(a3) + 4'(b3) + 4'(c3));
      step();
    end
    in_valid3 = 1'b0;
    out_ready3 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the team's single-bit full_adder cell.
- Each cycle, one operand bit pair plus a registered carry passes through the cell, LSB first.
- The cell's carry output is fed back through a flip-flop, and sum bits are shifted into a result register.
- Sits downstream of operand sources and feeds any valid/ready consumer. It is the area-cheap alternative to a ripple-carry array.

Parameters:
- W, 8, operand width in bits; legal range 1..64.
- CNT_W, $clog2(W+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept operands
- op_a  input  W  operand A
- op_b  input  W  operand B
- cin  input  1  carry-in for bit 0
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  W  result bits
- cout  output  1  carry-out from bit W-1
- busy  output  1  high in SHIFT or DONE

Interface rule (already decided): one clock, clk; reset rst_n is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - sum=0, cout=0.
  - carry flop=0, bit counter=0, operand shift registers=0.
- Reset asserted mid-operation aborts it immediately. No partial result is ever presented.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready at a clock edge:
    - load op_a and op_b into shift registers;
    - load cin into the carry flop;
    - clear the counter and the sum register;
    - go to SHIFT.
  - SHIFT: in_ready=0. Each edge:
    - cell inputs are a_sr[0], b_sr[0], carry flop;
    - cell sum shifts into sum register MSB, sum register shifts right;
    - cell carry is stored in the carry flop;
    - a_sr and b_sr shift right;
    - counter increments.
    - On the edge where counter==W-1: go to DONE, and cout takes the cell carry from that edge.
  - DONE: out_valid=1; sum and cout are held stable.
    - On out_ready=1 at an edge: go to IDLE, out_valid=0.
    - While out_ready=0: hold indefinitely (backpressure).
- Latency:
  - out_valid rises exactly W edges after the accepting edge.
  - Minimum issue interval is W+2 cycles (accept, W shifts, DONE handshake; in_ready returns in IDLE).
- Inputs are ignored outside IDLE:
  - in_valid while busy has no effect;
  - op_a/op_b/cin may change freely after acceptance.
- Arithmetic: {cout,sum} equals op_a+op_b+cin, modulo 2^(W+1), unsigned. There is no truncation inside the block.
- W=1: a single SHIFT edge, then DONE.
- All outputs are registered except in_ready and busy, which are decoded directly from state.
- No same-cycle accept and release: a result handshake in DONE returns to IDLE. The next accept happens at the earliest on the following edge.

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- When defined:
  - adds output port ovf (1 bit), the signed two's-complement overflow flag;
  - ovf = (carry into bit W-1) XOR (carry out of bit W-1);
  - captured on the final SHIFT edge, held in DONE, reset to 0.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package serial_adder_pkg holds:
  - state enum typedef: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10;
  - default width constant SA_W_DEFAULT=8.
- Sub-module: one instance of full_adder (gate-level cell: a, b, c, sum, carry) as the datapath bit slice.
- All sequencing stays in serial_adder.

Test Plan:
1. Reset mid-SHIFT: accept 8'hFF+8'h01, pull rst_n low after 3 shifts -> outputs immediately 0, in_ready=1, and no out_valid afterwards.
2. Basic add, W=8: op_a=8'h3C, op_b=8'h0A, cin=0 -> out_valid exactly 8 edges after accept, sum=8'h46, cout=0.
3. Full carry chain: op_a=8'hFF, op_b=8'h00, cin=1 -> sum=8'h00, cout=1; with the macro defined, ovf=0.
4. Signed overflow (macro defined): op_a=8'h7F, op_b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1. Then 8'h80+8'h80 -> sum=8'h00, cout=1, ovf=1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1 with sum/cout unchanged, and in_ready stays 0 while in_valid is asserted with new data. Release -> IDLE next edge, in_ready=1.
6. Back-to-back exhaustive: W=3, all 128 (a,b,cin) combinations with in_valid held high and out_ready=1 -> every result matches a+b+cin, issue interval is exactly W+2=5 cycles.
